// File: rtl/sprite_bus_pkg.sv
// Shared sprite-core bus map, command encodings and loader FSM states.
package sprite_bus_pkg;

  // Sprite-core register addresses (addr[13] set selects registers)
  localparam logic [13:0] BusAddrBypass = 14'h2000;
  localparam logic [13:0] BusAddrX0     = 14'h2001;
  localparam logic [13:0] BusAddrY0     = 14'h2002;

  typedef enum logic [1:0] {
    OpLoad      = 2'd0,
    OpSetPos    = 2'd1,
    OpSetBypass = 2'd2,
    OpReserved  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StPix     = 3'd2,
    StCommitX = 3'd3,
    StCommitY = 3'd4,
    StByp     = 3'd5
  } state_e;

endpackage

// File: rtl/pixel_unpack.sv
// Selects one packed pixel out of a 32-bit data word; pixel 0 sits in the LSBs.
module pixel_unpack #(
  parameter int unsigned PIX_W = 2,
  parameter int unsigned IDX_W = 4
) (
  input  logic [31:0]      word_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [PIX_W-1:0] pixel_o
);

  // Shift the selected pixel down to bit 0 and truncate
  always_comb begin
    pixel_o = PIX_W'(word_i >> (32'(idx_i) * PIX_W));
  end

endmodule

// File: rtl/sprite_load_engine.sv
// Sprite loader: streams packed pixel words into sprite RAM, and applies
// position/bypass updates to the sprite core over a simple strobe bus.
module sprite_load_engine
  import sprite_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PIX_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [10:0]           cmd_x,
  input  logic [10:0]           cmd_y,
  input  logic                  cmd_bypass,
  input  logic                  dat_valid,
  output logic                  dat_ready,
  input  logic [31:0]           dat_word,
  input  logic                  frame_start,
  output logic                  cs,
  output logic                  write,
  output logic [13:0]           addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PixPerWord = 32 / PIX_W;
  localparam int unsigned IdxW       = (PixPerWord > 1) ? $clog2(PixPerWord) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PixPerWord - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;       // address of the next pixel write
  logic [ADDR_WIDTH:0]   rem_q;       // pixels still to be written
  logic [IdxW-1:0]       pix_idx_q;   // index of the pixel currently on the bus
  logic [31:0]           word_q;
  logic [10:0]           pend_x_q;
  logic [10:0]           pend_y_q;
  logic                  pend_q;
  logic                  commit_req_q;
  logic                  rdy_q;       // holds cmd_ready low through reset
  logic                  cs_q;
  logic                  write_q;
  logic [13:0]           addr_q;
  logic [31:0]           wr_data_q;
  logic                  done_q;

  logic                  commit_due;
  logic                  cmd_hs;
  logic [31:0]           unpack_word;
  logic [IdxW-1:0]       unpack_idx;
  logic [PIX_W-1:0]      unpack_pixel;

  assign commit_due = pend_q && commit_req_q;
  assign cmd_ready  = rdy_q && (state_q == StIdle) && !commit_due;
  assign cmd_hs     = cmd_valid && cmd_ready;
  assign dat_ready  = (state_q == StFetch);
  assign busy       = (state_q != StIdle) || commit_req_q;
  assign cs         = cs_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;

  // Pixel 0 comes straight off the data port at the handshake; later pixels
  // come from the latched word.
  always_comb begin
    unpack_word = word_q;
    unpack_idx  = pix_idx_q + 1'b1;
    if (state_q == StFetch) begin
      unpack_word = dat_word;
      unpack_idx  = '0;
    end
  end

  pixel_unpack #(
    .PIX_W (PIX_W),
    .IDX_W (IdxW)
  ) u_pixel_unpack (
    .word_i  (unpack_word),
    .idx_i   (unpack_idx),
    .pixel_o (unpack_pixel)
  );

  // Control FSM; bus strobes and done are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      rem_q        <= '0;
      pix_idx_q    <= '0;
      word_q       <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_q       <= 1'b0;
      commit_req_q <= 1'b0;
      rdy_q        <= 1'b0;
      cs_q         <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      cs_q    <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      // A vblank only matters when a position update is waiting
      if (frame_start && pend_q) begin
        commit_req_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (commit_due) begin
            state_q   <= StCommitX;
            cs_q      <= 1'b1;
            write_q   <= 1'b1;
            addr_q    <= BusAddrX0;
            wr_data_q <= 32'(pend_x_q);
          end else if (cmd_hs) begin
            case (cmd_op_e'(cmd_op))
              OpLoad: begin
                if (cmd_len == '0) begin
                  done_q <= 1'b1;
                end else begin
                  ptr_q   <= cmd_base;
                  rem_q   <= cmd_len;
                  state_q <= StFetch;
                end
              end
              OpSetPos: begin
                pend_x_q <= cmd_x;
                pend_y_q <= cmd_y;
                pend_q   <= 1'b1;
                done_q   <= 1'b1;
              end
              OpSetBypass: begin
                state_q   <= StByp;
                cs_q      <= 1'b1;
                write_q   <= 1'b1;
                addr_q    <= BusAddrBypass;
                wr_data_q <= 32'(cmd_bypass);
              end
              default: begin
                done_q <= 1'b1;
              end
            endcase
          end
        end
        StFetch: begin
          if (dat_valid) begin
            word_q    <= dat_word;
            pix_idx_q <= '0;
            state_q   <= StPix;
            cs_q      <= 1'b1;
            write_q   <= 1'b1;
            addr_q    <= 14'(ptr_q);
            wr_data_q <= 32'(unpack_pixel);
            ptr_q     <= ptr_q + 1'b1;
            rem_q     <= rem_q - 1'b1;
          end
        end
        StPix: begin
          if (rem_q == '0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (pix_idx_q == LastIdx) begin
            state_q <= StFetch;
          end else begin
            pix_idx_q <= pix_idx_q + 1'b1;
            cs_q      <= 1'b1;
            write_q   <= 1'b1;
            addr_q    <= 14'(ptr_q);
            wr_data_q <= 32'(unpack_pixel);
            ptr_q     <= ptr_q + 1'b1;
            rem_q     <= rem_q - 1'b1;
          end
        end
        StCommitX: begin
          state_q   <= StCommitY;
          cs_q      <= 1'b1;
          write_q   <= 1'b1;
          addr_q    <= BusAddrY0;
          wr_data_q <= 32'(pend_y_q);
        end
        StCommitY: begin
          state_q      <= StIdle;
          pend_q       <= 1'b0;
          commit_req_q <= 1'b0;
        end
        StByp: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_load_engine.sv
// Directed self-checking bench for sprite_load_engine.
module tb_sprite_load_engine;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_base;
  logic [10:0] cmd_len;
  logic [10:0] cmd_x;
  logic [10:0] cmd_y;
  logic        cmd_bypass;
  logic        dat_valid;
  logic        dat_ready;
  logic [31:0] dat_word;
  logic        frame_start;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int first_rdy = 0;

  logic [13:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  bit          wb[$];
  int          dc[$];

  sprite_load_engine #(
    .ADDR_WIDTH (10),
    .PIX_W      (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_base    (cmd_base),
    .cmd_len     (cmd_len),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_bypass  (cmd_bypass),
    .dat_valid   (dat_valid),
    .dat_ready   (dat_ready),
    .dat_word    (dat_word),
    .frame_start (frame_start),
    .cs          (cs),
    .write       (write),
    .addr        (addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus/done logger, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cs || write) begin
      wa.push_back(addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
      wb.push_back(cs && write);
    end
    if (done) dc.push_back(cyc);
    if (cmd_ready && first_rdy == 0) first_rdy = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wcyc(input int i);
    return (i < wc.size()) ? wc[i] : -1;
  endfunction

  function automatic int dcyc(input int i);
    return (i < dc.size()) ? dc[i] : -1;
  endfunction

  task automatic expect_wr(input string tag, input int i, input logic [13:0] a,
                           input logic [31:0] d);
    if (i < wa.size()) begin
      chk({tag, "_addr"}, 64'(wa[i]), 64'(a));
      chk({tag, "_data"}, 64'(wd[i]), 64'(d));
      chk({tag, "_strobe"}, 64'(wb[i]), 64'd1);
    end else begin
      chk({tag, "_count"}, 64'(wa.size()), 64'(i + 1));
    end
  endtask

  task automatic clear_log();
    #1;
    wa.delete(); wd.delete(); wc.delete(); wb.delete(); dc.delete();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [9:0] base, input logic [10:0] len,
                          input logic [10:0] x, input logic [10:0] y, input logic byp);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_base = base; cmd_len = len; cmd_x = x; cmd_y = y; cmd_bypass = byp;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    hs_cyc = cyc;
    #1;
    cmd_valid = 1'b0;
    // Scramble fields after the handshake; the DUT must have registered them
    cmd_op = 2'($urandom); cmd_base = 10'($urandom); cmd_len = 11'($urandom);
    cmd_x = 11'($urandom); cmd_y = 11'($urandom); cmd_bypass = ~byp;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    dat_word = w;
    dat_valid = 1'b1;
    while (!dat_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("dat_accept", 64'(dat_ready), 64'd1);
    @(posedge clk);
    #1;
    dat_valid = 1'b0;
    dat_word = $urandom;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_len = '0;
    cmd_x = '0; cmd_y = '0; cmd_bypass = 1'b0; dat_valid = 1'b0; dat_word = '0;
    frame_start = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_write", {62'd0, cs, write}, 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_done_busy", {62'd0, done, busy}, 64'd0);
    chk("rst_ready", {62'd0, cmd_ready, dat_ready}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // LOAD wrapping the top of the address space
    clear_log();
    send_cmd(2'd0, 10'h3FE, 11'd3, 11'd0, 11'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("t21_dat_ready", 64'(dat_ready), 64'd1);
    chk("t21_busy", 64'(busy), 64'd1);
    send_word(32'h0000_0039);
    repeat (8) @(negedge clk);
    chk("t21_nwr", 64'(wa.size()), 64'd3);
    expect_wr("t21_w0", 0, 14'h3FE, 32'd1);
    expect_wr("t21_w1", 1, 14'h3FF, 32'd2);
    expect_wr("t21_w2", 2, 14'h000, 32'd3);
    chk("t21_gap1", 64'(wcyc(1) - wcyc(0)), 64'd1);
    chk("t21_gap2", 64'(wcyc(2) - wcyc(1)), 64'd1);
    chk("t21_ndone", 64'(dc.size()), 64'd1);
    chk("t21_done_cyc", 64'(dcyc(0)), 64'(wcyc(2) + 1));

    // Two-word LOAD, partial final word
    clear_log();
    send_cmd(2'd0, 10'h000, 11'd20, 11'd0, 11'd0, 1'b0);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0000);
    repeat (10) @(negedge clk);
    #1;
    chk("t22_nwr", 64'(wa.size()), 64'd20);
    for (int i = 0; i < 20; i++) begin
      expect_wr($sformatf("t22_w%0d", i), i, 14'(i), (i < 16) ? 32'd3 : 32'd0);
    end
    chk("t22_ndone", 64'(dc.size()), 64'd1);
    chk("t22_dat_ready_after", 64'(dat_ready), 64'd0);

    // Zero-length LOAD
    clear_log();
    send_cmd(2'd0, 10'h055, 11'd0, 11'd0, 11'd0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("t08_nwr", 64'(wa.size()), 64'd0);
    chk("t08_done_cyc", 64'(dcyc(0)), 64'(hs_cyc + 1));
    chk("t08_idle_ready", 64'(cmd_ready), 64'd1);

    // Reserved opcode
    clear_log();
    send_cmd(2'd3, 10'h011, 11'd5, 11'd0, 11'd0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("t16_nwr", 64'(wa.size()), 64'd0);
    chk("t16_done_cyc", 64'(dcyc(0)), 64'(hs_cyc + 1));

    // SET_BYPASS
    clear_log();
    send_cmd(2'd2, 10'h000, 11'd0, 11'd0, 11'd0, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("t25_nwr", 64'(wa.size()), 64'd1);
    expect_wr("t25_w0", 0, 14'h2000, 32'd1);
    chk("t25_wr_cyc", 64'(wcyc(0)), 64'(hs_cyc + 1));
    chk("t25_done_cyc", 64'(dcyc(0)), 64'(hs_cyc + 2));

    // frame_start with nothing pending
    clear_log();
    pulse_frame();
    repeat (5) @(negedge clk);
    #1;
    chk("t24_nopend_nwr", 64'(wa.size()), 64'd0);
    chk("t24_nopend_busy", 64'(busy), 64'd0);

    // Overwritten SET_POS, then commit
    send_cmd(2'd1, 10'h000, 11'd0, 11'd1, 11'd2, 1'b0);
    send_cmd(2'd1, 10'h000, 11'd0, 11'd7, 11'd9, 1'b0);
    repeat (3) @(negedge clk);
    clear_log();
    pulse_frame();
    @(negedge clk);
    #1;
    chk("t24_ready_low", 64'(cmd_ready), 64'd0);
    chk("t24_busy", 64'(busy), 64'd1);
    repeat (6) @(negedge clk);
    #1;
    chk("t24_nwr", 64'(wa.size()), 64'd2);
    expect_wr("t24_x0", 0, 14'h2001, 32'd7);
    expect_wr("t24_y0", 1, 14'h2002, 32'd9);
    pulse_frame();
    repeat (5) @(negedge clk);
    #1;
    chk("t24_no_recommit", 64'(wa.size()), 64'd2);

    // frame_start during a LOAD defers the commit until the load completes
    send_cmd(2'd1, 10'h000, 11'd0, 11'd100, 11'd50, 1'b0);
    repeat (3) @(negedge clk);
    clear_log();
    send_cmd(2'd0, 10'h040, 11'd16, 11'd0, 11'd0, 1'b0);
    send_word(32'hE4E4_E4E4);
    pulse_frame();
    first_rdy = 0;
    repeat (40) @(negedge clk);
    #1;
    chk("t23_nwr", 64'(wa.size()), 64'd18);
    for (int i = 0; i < 16; i++) begin
      expect_wr($sformatf("t23_p%0d", i), i, 14'h040 + 14'(i), 32'(i % 4));
    end
    expect_wr("t23_x0", 16, 14'h2001, 32'd100);
    expect_wr("t23_y0", 17, 14'h2002, 32'd50);
    chk("t23_done_cyc", 64'(dcyc(0)), 64'(wcyc(15) + 1));
    chk("t23_x_cyc", 64'(wcyc(16)), 64'(wcyc(15) + 2));
    chk("t23_y_cyc", 64'(wcyc(17)), 64'(wcyc(16) + 1));
    chk("t23_ready_cyc", 64'(first_rdy), 64'(wcyc(17) + 1));

    // Reset in the middle of a LOAD, with a position update pending
    send_cmd(2'd1, 10'h000, 11'd0, 11'd5, 11'd6, 1'b0);
    repeat (3) @(negedge clk);
    clear_log();
    send_cmd(2'd0, 10'h100, 11'd16, 11'd0, 11'd0, 1'b0);
    send_word(32'hFFFF_FFFF);
    n = 0;
    while (wa.size() < 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t26_reached5", 64'(wa.size()), 64'd5);
    reset_n = 1'b0;
    #1;
    chk("t26_async_cs", {62'd0, cs, write}, 64'd0);
    chk("t26_async_busy", 64'(busy), 64'd0);
    chk("t26_async_ready", {62'd0, cmd_ready, dat_ready}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("t26_nwr", 64'(wa.size()), 64'd5);
    chk("t26_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t26_busy", 64'(busy), 64'd0);
    pulse_frame();
    repeat (5) @(negedge clk);
    #1;
    chk("t26_pend_cleared", 64'(wa.size()), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
